// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station slice.
//   st_type_t    : functional-unit class a station serves (AL/BR/LS/MD)
//   instr_name_t : decoded instruction name; UNKNOWN marks an issue bubble
//   rs_entry_t   : per-entry control state (operand data/tags are held in
//                  parameter-sized arrays in the station itself)
package structures;

   typedef enum logic [1:0] {AL, BR, LS, MD} st_type_t;

   typedef enum logic [3:0] {
      UNKNOWN, ADD, SUB, SLL, SLT, XOR, BEQ, BNE, LW, SW, MUL, DIV
   } instr_name_t;

   typedef struct packed {
      logic        valid;
      instr_name_t name;
      logic        src1_rdy;
      logic        src2_rdy;
   } rs_entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Bus between the issuer / CDB / functional unit and a reservation station.
//   in_*        : two issue slots (index 0 is the older instruction)
//   cdb_*       : result broadcast used for operand wakeup
//   flush       : squash of all held work
//   full        : fewer than two free entries
//   out_*       : dispatch to the functional unit (valid/ready handshake)
// master = issuer/FU side, slave = reservation station.
interface reservation_station_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 6
) ();
   import structures::*;

   logic [1:0]       in_valid;
   st_type_t         in_st_type   [2];
   instr_name_t      in_name      [2];
   logic [XLEN-1:0]  in_address   [2];
   logic [XLEN-1:0]  in_immediate [2];
   logic [TAG_W-1:0] in_src1_tag  [2];
   logic [TAG_W-1:0] in_src2_tag  [2];
   logic [TAG_W-1:0] in_dst_tag   [2];
   logic [1:0]       in_src1_rdy;
   logic [1:0]       in_src2_rdy;
   logic [XLEN-1:0]  in_src1_data [2];
   logic [XLEN-1:0]  in_src2_data [2];

   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_data;

   logic             flush;
   logic             full;

   logic             out_valid;
   logic             out_ready;
   instr_name_t      out_name;
   logic [XLEN-1:0]  out_address;
   logic [XLEN-1:0]  out_immediate;
   logic [XLEN-1:0]  out_src1;
   logic [XLEN-1:0]  out_src2;
   logic [TAG_W-1:0] out_dst_tag;

   modport master (
      output in_valid, in_st_type, in_name, in_address, in_immediate,
             in_src1_tag, in_src2_tag, in_dst_tag, in_src1_rdy, in_src2_rdy,
             in_src1_data, in_src2_data, cdb_valid, cdb_tag, cdb_data,
             flush, out_ready,
      input  full, out_valid, out_name, out_address, out_immediate,
             out_src1, out_src2, out_dst_tag
   );

   modport slave (
      input  in_valid, in_st_type, in_name, in_address, in_immediate,
             in_src1_tag, in_src2_tag, in_dst_tag, in_src1_rdy, in_src2_rdy,
             in_src1_data, in_src2_data, cdb_valid, cdb_tag, cdb_data,
             flush, out_ready,
      output full, out_valid, out_name, out_address, out_immediate,
             out_src1, out_src2, out_dst_tag
   );

endinterface

// File: rtl/reservation_station_rs_select.sv
// rs_select: lowest-index priority encoder returning the PICKS lowest set
// bits of req, in ascending index order.
//   req : request vector
//   vld : vld[p] set when a p-th request exists
//   idx : index of the p-th lowest request
module rs_select #(
   parameter  int N     = 8,
   parameter  int PICKS = 1,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]                  req,
   output logic [PICKS-1:0]              vld,
   output logic [PICKS-1:0][IDX_W-1:0]   idx
);

   logic [N-1:0] rem;

   always_comb begin
      rem = req;
      vld = '0;
      idx = '0;
      for (int p = 0; p < PICKS; p++) begin
         // descending scan so the lowest set bit is the last one written
         for (int i = N - 1; i >= 0; i--) begin
            if (rem[i]) begin
               vld[p] = 1'b1;
               idx[p] = IDX_W'(i);
            end
         end
         if (vld[p]) rem[idx[p]] = 1'b0;
      end
   end

endmodule

// File: rtl/reservation_station.sv
// reservation_station: DEPTH-entry station for one unit type (ST_TYPE).
// Accepts up to two issue slots per cycle into the lowest free entries,
// wakes operands from the CDB (including same-cycle issue), and dispatches
// the lowest-index ready entry into a registered valid/ready output stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reservation_station_if.slave (issue, CDB, flush, full, dispatch)
// Optional macro RS_DISPATCH_BYPASS_EN: a ready slot may go straight to the
// output register when it is free and no held entry is eligible.
module reservation_station
   import structures::*;
#(
   parameter int       XLEN    = 32,
   parameter int       DEPTH   = 8,
   parameter int       TAG_W   = 6,
   parameter st_type_t ST_TYPE = AL
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reservation_station_if.slave  bus
);

   localparam int IDX_W = $clog2(DEPTH);

   rs_entry_t        ent       [DEPTH];
   logic [TAG_W-1:0] src1_tag  [DEPTH];
   logic [TAG_W-1:0] src2_tag  [DEPTH];
   logic [TAG_W-1:0] dst_tag   [DEPTH];
   logic [XLEN-1:0]  src1_val  [DEPTH];
   logic [XLEN-1:0]  src2_val  [DEPTH];
   logic [XLEN-1:0]  address   [DEPTH];
   logic [XLEN-1:0]  immediate [DEPTH];

   logic [DEPTH-1:0] valid_q, valid_n, eligible, wake1, wake2;
   logic [1:0]       acc, byp, need, alloc, s1_rdy, s2_rdy;
   logic [XLEN-1:0]  s1_val [2];
   logic [XLEN-1:0]  s2_val [2];
   logic [IDX_W-1:0] alloc_idx [2];
   logic [0:0]              sel_vld;
   logic [0:0][IDX_W-1:0]   sel_idx;
   logic [1:0]              free_vld;
   logic [1:0][IDX_W-1:0]   free_idx;
   logic             load_out, dispatch, slot1_fvld, overflow, byp_slot;
   logic [IDX_W:0]   free_cnt;

   // incoming slots: acceptance and same-cycle CDB wakeup
   always_comb begin
      acc    = '0;
      s1_rdy = '0;
      s2_rdy = '0;
      for (int i = 0; i < 2; i++) begin
         acc[i]    = bus.in_valid[i] && (bus.in_st_type[i] == ST_TYPE) &&
                     (bus.in_name[i] != UNKNOWN);
         s1_rdy[i] = bus.in_src1_rdy[i] ||
                     (bus.cdb_valid && bus.cdb_tag == bus.in_src1_tag[i]);
         s2_rdy[i] = bus.in_src2_rdy[i] ||
                     (bus.cdb_valid && bus.cdb_tag == bus.in_src2_tag[i]);
         s1_val[i] = bus.in_src1_rdy[i] ? bus.in_src1_data[i] : bus.cdb_data;
         s2_val[i] = bus.in_src2_rdy[i] ? bus.in_src2_data[i] : bus.cdb_data;
      end
   end

   // held entries: eligibility and CDB wakeup
   always_comb begin
      valid_q  = '0;
      eligible = '0;
      wake1    = '0;
      wake2    = '0;
      for (int e = 0; e < DEPTH; e++) begin
         valid_q[e]  = ent[e].valid;
         eligible[e] = ent[e].valid && ent[e].src1_rdy && ent[e].src2_rdy;
         wake1[e]    = ent[e].valid && !ent[e].src1_rdy && bus.cdb_valid &&
                       bus.cdb_tag == src1_tag[e];
         wake2[e]    = ent[e].valid && !ent[e].src2_rdy && bus.cdb_valid &&
                       bus.cdb_tag == src2_tag[e];
      end
   end

   rs_select #(.N(DEPTH), .PICKS(1)) u_sel_issue (
      .req (eligible),
      .vld (sel_vld),
      .idx (sel_idx)
   );

   // free list comes from the current valid bits, so an entry freed by
   // dispatch this edge only becomes allocatable next cycle
   rs_select #(.N(DEPTH), .PICKS(2)) u_sel_free (
      .req (~valid_q),
      .vld (free_vld),
      .idx (free_idx)
   );

   assign load_out = !bus.out_valid || bus.out_ready;
   assign dispatch = load_out && sel_vld[0];

`ifdef RS_DISPATCH_BYPASS_EN
   always_comb begin
      byp = '0;
      if (load_out && !sel_vld[0]) begin
         if (acc[0] && s1_rdy[0] && s2_rdy[0])      byp[0] = 1'b1;
         else if (acc[1] && s1_rdy[1] && s2_rdy[1]) byp[1] = 1'b1;
      end
   end
`else
   assign byp = '0;
`endif
   assign byp_slot = !byp[0];

   // slot 1 takes the second free entry only when slot 0 also allocates
   assign need         = acc & ~byp;
   assign slot1_fvld   = need[0] ? free_vld[1] : free_vld[0];
   assign alloc[0]     = need[0] && free_vld[0];
   assign alloc[1]     = need[1] && slot1_fvld;
   assign alloc_idx[0] = free_idx[0];
   assign alloc_idx[1] = need[0] ? free_idx[1] : free_idx[0];
   assign overflow     = !bus.flush &&
                         ((need[0] && !free_vld[0]) || (need[1] && !slot1_fvld));

   always_comb begin
      valid_n = valid_q;
      if (dispatch) valid_n[sel_idx[0]] = 1'b0;
      for (int i = 0; i < 2; i++)
         if (alloc[i]) valid_n[alloc_idx[i]] = 1'b1;
      if (bus.flush) valid_n = '0;
      free_cnt = '0;
      for (int e = 0; e < DEPTH; e++)
         free_cnt = free_cnt + (IDX_W+1)'(!valid_n[e]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
         bus.full <= 1'b0;
      end else begin
         bus.full <= free_cnt < (IDX_W+1)'(2);
         for (int e = 0; e < DEPTH; e++) begin
            ent[e].valid <= valid_n[e];
            if (wake1[e]) ent[e].src1_rdy <= 1'b1;
            if (wake2[e]) ent[e].src2_rdy <= 1'b1;
         end
         for (int i = 0; i < 2; i++) begin
            if (alloc[i]) begin
               ent[alloc_idx[i]].name     <= bus.in_name[i];
               ent[alloc_idx[i]].src1_rdy <= s1_rdy[i];
               ent[alloc_idx[i]].src2_rdy <= s2_rdy[i];
            end
         end
      end
   end

   // payload storage needs no reset: it is only read behind a valid bit
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         if (wake1[e]) src1_val[e] <= bus.cdb_data;
         if (wake2[e]) src2_val[e] <= bus.cdb_data;
      end
      for (int i = 0; i < 2; i++) begin
         if (alloc[i]) begin
            src1_tag[alloc_idx[i]]  <= bus.in_src1_tag[i];
            src2_tag[alloc_idx[i]]  <= bus.in_src2_tag[i];
            dst_tag[alloc_idx[i]]   <= bus.in_dst_tag[i];
            src1_val[alloc_idx[i]]  <= s1_val[i];
            src2_val[alloc_idx[i]]  <= s2_val[i];
            address[alloc_idx[i]]   <= bus.in_address[i];
            immediate[alloc_idx[i]] <= bus.in_immediate[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid     <= 1'b0;
         bus.out_name      <= UNKNOWN;
         bus.out_address   <= '0;
         bus.out_immediate <= '0;
         bus.out_src1      <= '0;
         bus.out_src2      <= '0;
         bus.out_dst_tag   <= '0;
      end else if (bus.flush) begin
         bus.out_valid <= 1'b0;
      end else if (load_out) begin
         if (dispatch) begin
            bus.out_valid     <= 1'b1;
            bus.out_name      <= ent[sel_idx[0]].name;
            bus.out_address   <= address[sel_idx[0]];
            bus.out_immediate <= immediate[sel_idx[0]];
            bus.out_src1      <= src1_val[sel_idx[0]];
            bus.out_src2      <= src2_val[sel_idx[0]];
            bus.out_dst_tag   <= dst_tag[sel_idx[0]];
         end else if (|byp) begin
            bus.out_valid     <= 1'b1;
            bus.out_name      <= bus.in_name[byp_slot];
            bus.out_address   <= bus.in_address[byp_slot];
            bus.out_immediate <= bus.in_immediate[byp_slot];
            bus.out_src1      <= s1_val[byp_slot];
            bus.out_src2      <= s2_val[byp_slot];
            bus.out_dst_tag   <= bus.in_dst_tag[byp_slot];
         end else begin
            bus.out_valid <= 1'b0;
         end
      end
   end

   // issuer must respect full; an accepted slot with nowhere to go is a bug
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow);

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/address width.
REQ-002 Parameter DEPTH, default 8, SHALL set the entry count (power of two, >=2).
REQ-003 Parameter TAG_W, default 6, SHALL set the rename tag width.
REQ-004 Parameter ST_TYPE, default AL, SHALL select the accepted station type (AL/BR/LS/MD).
REQ-005 clock  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid[0:1]  in  1 each  issue slot carries an instruction.
REQ-008 in_st_type[0:1]  in  st_type_t  target station type.
REQ-009 in_name[0:1]  in  instr_name_t  instruction name; UNKNOWN means bubble.
REQ-010 in_address[0:1], in_immediate[0:1]  in  XLEN  PC and immediate.
REQ-011 in_src1_tag[0:1], in_src2_tag[0:1], in_dst_tag[0:1]  in  TAG_W  rename tags.
REQ-012 in_src1_rdy[0:1], in_src2_rdy[0:1]  in  1  operand value already present.
REQ-013 in_src1_data[0:1], in_src2_data[0:1]  in  XLEN  operand values (valid when rdy).
REQ-014 cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  XLEN  result broadcast.
REQ-015 flush  in  1  synchronous squash of all held work.
REQ-016 full  out  1  fewer than two free entries (feeds issuer fullness).
REQ-017 out_valid  out  1; out_ready  in  1  dispatch handshake to functional unit.
REQ-018 out_name, out_address, out_immediate, out_src1, out_src2, out_dst_tag  out  matching widths  dispatched instruction.

Function
REQ-019 Slot i SHALL be accepted when in_valid[i], in_st_type[i]==ST_TYPE and in_name[i]!=UNKNOWN.
REQ-020 Accepted slots SHALL occupy the lowest-index free entries, slot 0 taking the lower index; entry valid from the next edge.
REQ-021 full SHALL be registered and equal (free entries after this edge < 2).
REQ-022 Acceptance with no free entry SHALL drop the slot and pulse overflow (simulation assertion only).
REQ-023 On cdb_valid, every held entry with a non-ready source whose tag equals cdb_tag SHALL capture cdb_data and set ready at the edge.
REQ-024 An instruction accepted in the same cycle as a matching CDB broadcast SHALL capture cdb_data (no lost wakeup).
REQ-025 An entry is eligible when valid and both sources ready; the lowest-index eligible entry SHALL be selected.
REQ-026 Output register SHALL load the selected entry when out_valid==0 or (out_valid & out_ready); the entry frees at that edge.
REQ-027 out_valid with unchanged payload SHALL hold while out_ready==0.
REQ-028 An entry freed by dispatch SHALL be reusable by allocation on the next cycle, not the same one.
REQ-029 Baseline latency: accept at edge N, earliest out_valid after edge N+1.
REQ-030 flush SHALL clear all entries and out_valid at the edge, overriding allocation, wakeup and dispatch.

Reset
REQ-031 reset low SHALL immediately clear all entry valid bits, out_valid=0, full=0, payload outputs=0.
REQ-032 Reset mid-operation SHALL discard all held instructions with no dispatch.

Configuration
REQ-033 RS_DISPATCH_BYPASS_EN defined: an accepted slot with both sources ready (incl. REQ-024) SHALL load the output register directly when it is free and no held entry is eligible, latency one edge, no entry allocated; slot 0 before slot 1.
REQ-034 RS_DISPATCH_BYPASS_EN undefined: all instructions pass through an entry per REQ-029.

Structure
REQ-035 st_type_t, instr_name_t and an rs_entry_t struct SHALL reside in package structures.
REQ-036 Sub-module rs_select (lowest-index eligible/free priority encoder, instantiated twice) SHALL be used.

Verification
REQ-037 Reset, then issue two AL adds with ready operands 5,7 -> out_valid after 2 edges, out_src1=5, out_src2=7, then second instruction.
REQ-038 Issue src1_tag=3 not ready; cdb_valid, cdb_tag=3, cdb_data=0xDEAD next cycle -> dispatch with out_src1=0xDEAD.
REQ-039 Fill DEPTH-1=7 entries with out_ready=0 -> full=1; one dispatch -> full=0 on following edge.
REQ-040 in_st_type=BR on an AL station, or in_name=UNKNOWN -> nothing accepted, full unchanged.
REQ-041 Issue tag 9 in same cycle as cdb_tag=9 -> entry ready, dispatched without second broadcast.
REQ-042 flush with 4 entries and out_valid=1 -> out_valid=0, full=0 next edge, no later dispatch.
